// File: rtl/dbg_cmd_arbiter_if.sv
// Bundle of requester-side and debug-module-side signals for dbg_cmd_arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface dbg_cmd_arbiter_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ*8-1:0]  req_cmd_i;
    logic [NREQ*32-1:0] req_addr_i;
    logic [NREQ*32-1:0] req_data_i;
    logic [NREQ*32-1:0] req_rdata_o;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ-1:0]    req_err_o;
    logic [7:0]         cmd_o;
    logic [31:0]        addr_o;
    logic [31:0]        data_o;
    logic [31:0]        data_i;
    logic               ready_i;
    logic [NREQ-1:0]    grant_o;
    logic               busy_o;

    modport master (
        input  req_cmd_i, req_addr_i, req_data_i, data_i, ready_i,
        output req_rdata_o, req_ready_o, req_err_o, cmd_o, addr_o, data_o,
               grant_o, busy_o
    );

    modport slave (
        output req_cmd_i, req_addr_i, req_data_i, data_i, ready_i,
        input  req_rdata_o, req_ready_o, req_err_o, cmd_o, addr_o, data_o,
               grant_o, busy_o
    );
endinterface

// File: rtl/dbg_cmd_arbiter.sv
// Round-robin arbiter sharing one debug-module command port between NREQ
// requesters, with per-command completion timeout.
module dbg_cmd_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rstn_i,
    dbg_cmd_arbiter_if.master bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [NREQ*32-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]    ready_q, ready_d;
    logic [NREQ-1:0]    err_q, err_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(NREQ - 1)) return '0;
        return v + 1'b1;
    endfunction

    // First requester at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin : pick_search
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && bus.req_cmd_i[int'(cand)*8 +: 8] != 8'h00) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tcnt_d  = tcnt_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    cmd_d   = bus.req_cmd_i[int'(pick_idx)*8 +: 8];
                    addr_d  = bus.req_addr_i[int'(pick_idx)*32 +: 32];
                    data_d  = bus.req_data_i[int'(pick_idx)*32 +: 32];
                    tcnt_d  = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                tcnt_d = tcnt_q + 1'b1;
                // A completion in the final allowed cycle still counts as success.
                if (bus.ready_i) begin
                    rdata_d[int'(owner_q)*32 +: 32] = bus.data_i;
                    ready_d[owner_q]                = 1'b1;
                    state_d                         = S_RELEASE;
                end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d[owner_q]   = 1'b1;
                    ready_d[owner_q] = 1'b1;
                    state_d          = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (bus.req_cmd_i[int'(owner_q)*8 +: 8] == 8'h00) begin
                    ready_d = '0;
                    err_d   = '0;
                    grant_d = '0;
                    rr_d    = wrap_inc(owner_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            grant_q <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tcnt_q  <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tcnt_q  <= tcnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_o       = (state_q == S_EXEC) ? cmd_q : 8'h00;
    assign bus.addr_o      = addr_q;
    assign bus.data_o      = data_q;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.req_rdata_o = rdata_q;
    assign bus.req_ready_o = ready_q;
    assign bus.req_err_o   = err_q;
endmodule
